// File: rtl/rr_mux_nto1.sv
// Registered N-to-1 mux with valid/ready handshakes and round-robin arbitration.
// Optional packet locking (in_last/out_last) is enabled by defining RR_MUX_PKT_LOCK_EN.
module rr_mux_nto1 #(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [N-1:0]   in_last,
  output logic           out_last,
`endif
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [W-1:0]  ch_data [N];
  logic [SW-1:0] last_grant;
  logic [SW-1:0] gnt_idx;
  logic [N-1:0]  gnt;
  logic          found;
  logic          load;
  logic          xfer;
`ifdef RR_MUX_PKT_LOCK_EN
  logic          locked;
  logic [SW-1:0] lock_ch;
`endif

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*W +: W];
  end

  assign load = ~out_valid | out_ready;

  // Search upward from the channel after the last grant, wrapping at N-1.
  always_comb begin
    int idx;
    logic [SW-1:0] idx_sw;
    idx     = 0;
    idx_sw  = '0;
    gnt_idx = '0;
    found   = 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
    if (locked) begin
      gnt_idx = lock_ch;
      found   = in_valid[lock_ch];
    end else begin
`endif
      for (int k = 1; k <= N; k++) begin
        idx    = (int'(last_grant) + k) % N;
        idx_sw = SW'(idx);
        if (!found && in_valid[idx_sw]) begin
          found   = 1'b1;
          gnt_idx = idx_sw;
        end
      end
`ifdef RR_MUX_PKT_LOCK_EN
    end
`endif
    gnt = found ? (N'(1) << gnt_idx) : '0;
  end

  assign in_ready = gnt & {N{load & rst_n}};
  assign xfer     = found & load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SW'(N - 1);
`ifdef RR_MUX_PKT_LOCK_EN
      out_last   <= 1'b0;
      locked     <= 1'b0;
      lock_ch    <= '0;
`endif
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt_idx];
        out_sel   <= gnt_idx;
`ifdef RR_MUX_PKT_LOCK_EN
        out_last  <= in_last[gnt_idx];
        // Pointer advances only at packet end so the next packet is arbitrated fairly.
        if (in_last[gnt_idx]) begin
          last_grant <= gnt_idx;
          locked     <= 1'b0;
        end else begin
          locked     <= 1'b1;
          lock_ch    <= gnt_idx;
        end
`else
        last_grant <= gnt_idx;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_nto1.sv
// Directed self-checking bench for rr_mux_nto1 (N=8, W=8).
// Packet-lock steps run only when RR_MUX_PKT_LOCK_EN is defined.
module tb_rr_mux_nto1;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  int checks = 0;
  int errors = 0;

  rr_mux_nto1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [2:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  task automatic load_rr_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'h10 + i);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    load_rr_data();
`ifdef RR_MUX_PKT_LOCK_EN
    in_last   = 8'hFF;
`endif

    // Reset held for two edges with all channels valid
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst.in_ready", 32'(in_ready), 32'h0);
      chk_out("rst", 1'b0, 8'h00, 3'd0);
    end

    // Single active channel 2
    rst_n    = 1'b1;
    in_valid = 8'b0000_0100;
    in_data[2*W +: W] = 8'hAD;
    #1;
    chk("single.in_ready", 32'(in_ready), 32'h04);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out("single", 1'b1, 8'hAD, 3'd2);
      chk("single.in_ready_hold", 32'(in_ready), 32'h04);
    end

    // Nothing valid: output empties
    in_valid = 8'h00;
    tick();
    chk("idle.valid", 32'(out_valid), 32'h0);

    // Round-robin over all channels after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 8'hFF;
    load_rr_data();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_out("rr", 1'b1, 8'(8'h10 + (c % 8)), 3'(c % 8));
    end

    // Backpressure while channel 3 is on the output
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk_out("bp.pre", 1'b1, 8'h13, 3'd3);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.in_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("bp.hold", 1'b1, 8'h13, 3'd3);
    end
    out_ready = 1'b1;
    tick();
    chk_out("bp.release", 1'b1, 8'h14, 3'd4);

    // Sparse: channels 0 and 7 alternate
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 8'b1000_0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out("sparse", 1'b1, (c % 2 == 0) ? 8'h10 : 8'h17, (c % 2 == 0) ? 3'd0 : 3'd7);
    end

    // Reset mid-stream discards the pending beat and restores the pointer
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("midrst.valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    chk_out("midrst.first", 1'b1, 8'h10, 3'd0);
    tick();
    chk_out("midrst.second", 1'b1, 8'h17, 3'd7);

`ifdef RR_MUX_PKT_LOCK_EN
    // Channel 1 sends a 3-beat packet while channel 5 stays valid
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 8'b0010_0010;
    in_last  = 8'b0010_0000;
    tick();
    chk_out("lock.b1", 1'b1, 8'h11, 3'd1);
    chk("lock.b1.last", 32'(out_last), 32'h0);
    tick();
    chk_out("lock.b2", 1'b1, 8'h11, 3'd1);
    in_last = 8'b0010_0010;
    tick();
    chk_out("lock.b3", 1'b1, 8'h11, 3'd1);
    chk("lock.b3.last", 32'(out_last), 32'h1);
    tick();
    chk_out("lock.next", 1'b1, 8'h15, 3'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_mux_nto1.md
Name: rr_mux_nto1

Overview:
- Parametrised, registered N-to-1 multiplexer with per-channel valid/ready handshake and round-robin arbitration.
- Replaces the plain combinational select-driven mux wherever several producers share one downstream consumer.
- Selection is made internally by a fair arbiter, not by an external select input.
- The output is registered with a one-entry buffer and sustains one beat per cycle under backpressure.

Parameters:
- N, 8, number of input channels; legal range N >= 2.
- W, 8, data width per channel in bits.
- SW, $clog2(N), localparam, width of the channel-index output; not overridable.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational; at most one bit high per cycle.
- out_data  output  W  registered selected data.
- out_sel  output  SW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - out_valid = 0, out_data = 0, out_sel = 0.
  - Round-robin pointer last_grant = N-1, so channel 0 has top priority first.
  - in_ready reads all-zero while rst_n is low.
- Load enable: load = ~out_valid | out_ready.
  - The output register accepts a new beat when empty or when it drains in the same cycle.
- Arbitration (combinational):
  - Among asserted in_valid bits, grant the first channel found searching upward from (last_grant+1) mod N, wrapping past N-1 to 0.
  - gnt is one-hot or zero.
- in_ready = gnt & {N{load}}. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer edge:
  - out_data <= in_data[i]
  - out_sel <= i
  - out_valid <= 1
  - last_grant <= i
- No transfer while load = 1: out_valid <= 0.
- load = 0 (stalled, out_valid = 1, out_ready = 0): out_data, out_sel and out_valid hold; last_grant holds.
- Latency: one cycle from input handshake to out_valid.
- Throughput: one beat per cycle when out_ready stays high.
- Fairness: with all N channels continuously valid, grants rotate 0,1,…,N-1,0,… Each channel waits at most N-1 transfers.
- Single active channel: granted every cycle; the pointer does not block it.
- Simultaneous drain and load in one cycle is legal. No bubble is inserted.
- Reset mid-transfer: the pending output beat is discarded, not delivered, and the pointer returns to N-1.
- in_valid may drop without a handshake (no stability requirement on inputs). The arbiter re-evaluates every cycle.
- The output obeys AXI-style rules: once out_valid = 1, out_data and out_sel stay stable until out_ready.
- No internal storage beyond the one output entry.

Optional Feature:
- Macro: RR_MUX_PKT_LOCK_EN.
- Defined:
  - Adds input in_last [N-1:0].
  - Adds registered output out_last (reset 0), which follows the transferred beat.
  - After a transfer from channel i with in_last[i] = 0, the arbiter locks to i. Only channel i may be granted until a beat with in_last[i] = 1 transfers, so packets are never interleaved.
  - The pointer updates only on a beat with in_last = 1.
  - Reset clears the lock.
- Undefined: no in_last or out_last ports; every beat is arbitrated independently as above.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with all in_valid = 8'hFF -> in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0 throughout.
- Single channel: in_valid = 8'b0000_0100, in_data[2] = 8'hAD, out_ready = 1 -> next cycle out_valid = 1, out_data = 8'hAD, out_sel = 2. With in_valid held, the same grant repeats every cycle.
- Round-robin: in_valid = 8'hFF, channel i data = i+8'h10, out_ready = 1 for 10 cycles -> out_sel sequence 0,1,2,3,4,5,6,7,0,1 with matching data and no bubbles.
- Backpressure: during the all-valid stream, drop out_ready for 3 cycles while out_sel = 3 -> out_data and out_sel hold at 3/8'h13 and in_ready = 0. After release, the next beat is out_sel = 4.
- Sparse fairness: in_valid = 8'b1000_0001 continuously -> grants alternate 0,7,0,7. Reset asserted mid-stream -> out_valid = 0 next edge; first post-reset grant is channel 0.
- RR_MUX_PKT_LOCK_EN defined: channel 1 sends 3 beats with in_last on the 3rd while channel 5 is valid throughout -> out_sel = 1,1,1 then 5.
